// File: rtl/stopwatch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : stopwatch_pkg
// Brief    : Shared state encodings, BCD digit limits, time record type and
//            a small state-classification helper for the stopwatch block.
// Revision : 1.0 - initial release
// ============================================================================
package stopwatch_pkg;

  // Controller state encodings (also the value driven on the state port)
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;
  localparam logic [1:0] ST_LAP   = 2'd3;

  // Terminal values for decimal units digits and for the tens of sec/min
  localparam logic [3:0] DIGIT_MAX_9 = 4'd9;
  localparam logic [3:0] DIGIT_MAX_5 = 4'd5;

  // One complete mm:ss.cc reading, most significant digit first
  typedef struct packed {
    logic [3:0] min10;
    logic [3:0] min1;
    logic [3:0] sec10;
    logic [3:0] sec1;
    logic [3:0] csec10;
    logic [3:0] csec1;
  } bcd_time_t;

  // Time advances only in the two states where the watch is running
  function automatic logic is_counting(input logic [1:0] st);
    return (st == ST_RUN) || (st == ST_LAP);
  endfunction

endpackage : stopwatch_pkg
`default_nettype wire

// File: rtl/bcd_digit_cnt.sv
`default_nettype none
// ============================================================================
// Module   : bcd_digit_cnt
// Brief    : Single decimal digit counter 0..MAX with synchronous clear and a
//            combinational carry that fires on the increment that wraps it.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_digit_cnt
  import stopwatch_pkg::*;
#(
  parameter logic [3:0] MAX = DIGIT_MAX_9
) (
  input  logic       clk,
  input  logic       reset_p,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] digit,
  output logic       carry
);

  // Treat any value at or above the limit as terminal so the digit can never
  // walk into a non-BCD code, whatever it was left holding.
  assign carry = inc & (digit >= MAX);

  // Digit register: clear wins over increment, increment wraps to zero
  always_ff @(posedge clk) begin
    if (reset_p || clr) begin
      digit <= 4'd0;
    end else if (inc) begin
      digit <= carry ? 4'd0 : digit + 4'd1;
    end
  end

endmodule : bcd_digit_cnt
`default_nettype wire

// File: rtl/stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : stopwatch_ctrl
// Brief    : mm:ss.cc stopwatch controller - IDLE/RUN/PAUSE/LAP command FSM,
//            millisecond prescaler, six-digit BCD live time, lap latch and
//            registered display mux.
// Revision : 1.0 - initial release
// ============================================================================
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int MSEC_PER_CSEC = 10
) (
  input  logic       clk,
  input  logic       reset_p,
  input  logic       clk_msec,
  input  logic       btn_start,
  input  logic       btn_lap,
  input  logic       btn_clear,
  output logic [3:0] disp_min10,
  output logic [3:0] disp_min1,
  output logic [3:0] disp_sec10,
  output logic [3:0] disp_sec1,
  output logic [3:0] disp_csec10,
  output logic [3:0] disp_csec1,
  output logic [1:0] state,
  output logic       running,
  output logic       rollover
);

  // A one-tick hundredth still needs a one-bit prescaler to keep widths legal
  localparam int PRE_W = (MSEC_PER_CSEC > 1) ? $clog2(MSEC_PER_CSEC) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(MSEC_PER_CSEC - 1);

  logic [PRE_W-1:0] prescaler;
  logic [1:0]       state_nxt;
  logic             cmd_start;
  logic             cmd_lap;
  logic             cmd_clear;
  logic             tick;
  logic             csec_inc;
  logic             do_clear;
  logic             lap_capture;

  logic [3:0] live_csec1, live_csec10, live_sec1, live_sec10, live_min1, live_min10;
  logic       carry_csec1, carry_csec10, carry_sec1, carry_sec10, carry_min1, carry_min10;

  bcd_time_t live;
  bcd_time_t lap_latch;
  bcd_time_t disp;

  // One command per cycle: clear beats start beats lap
  assign cmd_clear = btn_clear;
  assign cmd_start = btn_start & ~btn_clear;
  assign cmd_lap   = btn_lap & ~btn_clear & ~btn_start;

  // Tick gating looks at the state before this edge's transition
  assign tick        = is_counting(state) & clk_msec;
  assign csec_inc    = tick & (prescaler == PRE_LAST);
  assign do_clear    = cmd_clear & (state == ST_PAUSE);
  assign lap_capture = cmd_lap & (state == ST_RUN);

  // Next-state decode for the command FSM; unlisted combinations hold
  always_comb begin
    state_nxt = state;
    if (cmd_clear) begin
      if (state == ST_PAUSE) state_nxt = ST_IDLE;
    end else if (cmd_start) begin
      case (state)
        ST_IDLE:  state_nxt = ST_RUN;
        ST_RUN:   state_nxt = ST_PAUSE;
        ST_LAP:   state_nxt = ST_PAUSE;
        ST_PAUSE: state_nxt = ST_RUN;
        default:  state_nxt = state;
      endcase
    end else if (cmd_lap) begin
      case (state)
        ST_RUN:  state_nxt = ST_LAP;
        ST_LAP:  state_nxt = ST_RUN;
        default: state_nxt = state;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset_p) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  // Prescaler: counts gated ticks, keeps its value across PAUSE
  always_ff @(posedge clk) begin
    if (reset_p || do_clear) begin
      prescaler <= '0;
    end else if (tick) begin
      prescaler <= (prescaler == PRE_LAST) ? '0 : prescaler + 1'b1;
    end
  end

  // Ripple-carry chain of digit counters, least significant first
  bcd_digit_cnt #(.MAX(DIGIT_MAX_9)) u_csec1 (
    .clk(clk), .reset_p(reset_p), .clr(do_clear), .inc(csec_inc),
    .digit(live_csec1), .carry(carry_csec1)
  );
  bcd_digit_cnt #(.MAX(DIGIT_MAX_9)) u_csec10 (
    .clk(clk), .reset_p(reset_p), .clr(do_clear), .inc(carry_csec1),
    .digit(live_csec10), .carry(carry_csec10)
  );
  bcd_digit_cnt #(.MAX(DIGIT_MAX_9)) u_sec1 (
    .clk(clk), .reset_p(reset_p), .clr(do_clear), .inc(carry_csec10),
    .digit(live_sec1), .carry(carry_sec1)
  );
  bcd_digit_cnt #(.MAX(DIGIT_MAX_5)) u_sec10 (
    .clk(clk), .reset_p(reset_p), .clr(do_clear), .inc(carry_sec1),
    .digit(live_sec10), .carry(carry_sec10)
  );
  bcd_digit_cnt #(.MAX(DIGIT_MAX_9)) u_min1 (
    .clk(clk), .reset_p(reset_p), .clr(do_clear), .inc(carry_sec10),
    .digit(live_min1), .carry(carry_min1)
  );
  bcd_digit_cnt #(.MAX(DIGIT_MAX_5)) u_min10 (
    .clk(clk), .reset_p(reset_p), .clr(do_clear), .inc(carry_min1),
    .digit(live_min10), .carry(carry_min10)
  );

  assign live = '{min10: live_min10, min1: live_min1, sec10: live_sec10,
                  sec1: live_sec1, csec10: live_csec10, csec1: live_csec1};

  // Lap latch holds the pre-increment live time seen on RUN+lap
  always_ff @(posedge clk) begin
    if (reset_p || do_clear) begin
      lap_latch <= '0;
    end else if (lap_capture) begin
      lap_latch <= live;
    end
  end

  // Display register: frozen lap value in LAP, live time otherwise
  always_ff @(posedge clk) begin
    if (reset_p) disp <= '0;
    else         disp <= (state == ST_LAP) ? lap_latch : live;
  end

  // Top-digit carry only occurs on the 59:59.99 -> 00:00.00 wrap
  always_ff @(posedge clk) begin
    if (reset_p) rollover <= 1'b0;
    else         rollover <= carry_min10;
  end

  assign running     = is_counting(state);
  assign disp_min10  = disp.min10;
  assign disp_min1   = disp.min1;
  assign disp_sec10  = disp.sec10;
  assign disp_sec1   = disp.sec1;
  assign disp_csec10 = disp.csec10;
  assign disp_csec1  = disp.csec1;

endmodule : stopwatch_ctrl
`default_nettype wire

// File: tb/tb_stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_stopwatch_ctrl
// Brief    : Self-checking bench for stopwatch_ctrl: directed scenarios plus
//            randomized commands/ticks against a hundredths-count model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stopwatch_ctrl;

  localparam int MSEC    = 10;
  localparam int MAX_HUN = 359999;   // 59:59.99 in hundredths

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main DUT (default prescale)
  logic reset_p, clk_msec, btn_start, btn_lap, btn_clear;
  logic [3:0] d_m10, d_m1, d_s10, d_s1, d_c10, d_c1;
  logic [1:0] state;
  logic       running, rollover;
  logic [23:0] disp_all;
  assign disp_all = {d_m10, d_m1, d_s10, d_s1, d_c10, d_c1};

  stopwatch_ctrl #(.MSEC_PER_CSEC(MSEC)) dut (
    .clk(clk), .reset_p(reset_p), .clk_msec(clk_msec),
    .btn_start(btn_start), .btn_lap(btn_lap), .btn_clear(btn_clear),
    .disp_min10(d_m10), .disp_min1(d_m1), .disp_sec10(d_s10),
    .disp_sec1(d_s1), .disp_csec10(d_c10), .disp_csec1(d_c1),
    .state(state), .running(running), .rollover(rollover)
  );

  // Second DUT with one tick per hundredth for the wrap scenario
  logic ro_reset, ro_msec, ro_start;
  logic [3:0] ro_m10, ro_m1, ro_s10, ro_s1, ro_c10, ro_c1;
  logic [1:0] ro_state;
  logic       ro_running, ro_rollover;
  logic [23:0] ro_disp;
  assign ro_disp = {ro_m10, ro_m1, ro_s10, ro_s1, ro_c10, ro_c1};

  stopwatch_ctrl #(.MSEC_PER_CSEC(1)) dut_r (
    .clk(clk), .reset_p(ro_reset), .clk_msec(ro_msec),
    .btn_start(ro_start), .btn_lap(1'b0), .btn_clear(1'b0),
    .disp_min10(ro_m10), .disp_min1(ro_m1), .disp_sec10(ro_s10),
    .disp_sec1(ro_s1), .disp_csec10(ro_c10), .disp_csec1(ro_c1),
    .state(ro_state), .running(ro_running), .rollover(ro_rollover)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: time kept as a plain count of hundredths
  int m_state, m_pre, m_live, m_lap, m_disp;
  bit m_roll;

  function automatic logic [23:0] to_bcd(input int h);
    int mn, s, c;
    mn = h / 6000;
    s  = (h / 100) % 60;
    c  = h % 100;
    return {4'(mn / 10), 4'(mn % 10), 4'(s / 10), 4'(s % 10), 4'(c / 10), 4'(c % 10)};
  endfunction

  task automatic model_step(input bit st, input bit lp, input bit cl, input bit ms, input bit rs);
    int old_live;
    bit counting;
    if (rs) begin
      m_state = 0; m_pre = 0; m_live = 0; m_lap = 0; m_disp = 0; m_roll = 0;
      return;
    end
    old_live = m_live;
    m_disp   = (m_state == 3) ? m_lap : m_live;
    m_roll   = 0;
    counting = (m_state == 1) || (m_state == 3);
    if (counting && ms) begin
      m_pre++;
      if (m_pre == MSEC) begin
        m_pre = 0;
        if (m_live == MAX_HUN) begin
          m_live = 0;
          m_roll = 1;
        end else begin
          m_live++;
        end
      end
    end
    if (cl) begin
      if (m_state == 2) begin
        m_state = 0; m_pre = 0; m_live = 0; m_lap = 0;
      end
    end else if (st) begin
      m_state = (m_state == 1 || m_state == 3) ? 2 : 1;
    end else if (lp) begin
      if (m_state == 1) begin
        m_state = 3;
        m_lap   = old_live;
      end else if (m_state == 3) begin
        m_state = 1;
      end
    end
  endtask

  // One clock: drive at negedge, model at posedge, compare at next negedge
  task automatic cycle(input bit st, input bit lp, input bit cl, input bit ms, input bit rs);
    btn_start = st; btn_lap = lp; btn_clear = cl; clk_msec = ms; reset_p = rs;
    @(posedge clk);
    model_step(st, lp, cl, ms, rs);
    @(negedge clk);
    btn_start = 0; btn_lap = 0; btn_clear = 0; clk_msec = 0; reset_p = 0;
    check("disp", 32'(disp_all), 32'(to_bcd(m_disp)));
    check("state", 32'(state), 32'(m_state));
    check("running", 32'(running), 32'((m_state == 1) || (m_state == 3)));
    check("rollover", 32'(rollover), 32'(m_roll));
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 1, 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0);
  endtask

  task automatic ro_cycle(input bit st, input bit ms, input bit rs);
    ro_start = st; ro_msec = ms; ro_reset = rs;
    @(posedge clk);
    @(negedge clk);
    ro_start = 0; ro_msec = 0; ro_reset = 0;
  endtask

  initial begin
    int ro_pulses;
    reset_p = 1; clk_msec = 0; btn_start = 0; btn_lap = 0; btn_clear = 0;
    ro_reset = 1; ro_msec = 0; ro_start = 0;
    m_state = 0; m_pre = 0; m_live = 0; m_lap = 0; m_disp = 0; m_roll = 0;
    @(negedge clk);

    // Reset state
    cycle(0, 0, 0, 0, 1);
    cycle(0, 0, 0, 1, 1);
    check("rst_disp", 32'(disp_all), 32'h0);
    check("rst_state", 32'(state), 32'd0);
    check("rst_running", 32'(running), 32'd0);

    // Count: 1000 ms -> 00:01.00
    cycle(1, 0, 0, 0, 0);
    ticks(1000);
    idle(2);
    check("count_disp", 32'(disp_all), 32'h000100);
    check("count_state", 32'(state), 32'd1);
    check("count_running", 32'(running), 32'd1);

    // Pause/clear: clear ignored in RUN, held in PAUSE, clear to IDLE
    ticks(1000);
    cycle(0, 0, 1, 0, 0);
    idle(1);
    check("clr_run_state", 32'(state), 32'd1);
    check("clr_run_disp", 32'(disp_all), 32'h000200);
    cycle(1, 0, 0, 0, 0);
    ticks(500);
    idle(2);
    check("pause_state", 32'(state), 32'd2);
    check("pause_disp", 32'(disp_all), 32'h000200);
    cycle(0, 0, 1, 0, 0);
    idle(2);
    check("clear_state", 32'(state), 32'd0);
    check("clear_disp", 32'(disp_all), 32'h0);

    // Lap freeze and release
    cycle(1, 0, 0, 0, 0);
    ticks(500);
    cycle(0, 1, 0, 0, 0);
    ticks(300);
    idle(1);
    check("lap_disp", 32'(disp_all), 32'h000050);
    check("lap_state", 32'(state), 32'd3);
    cycle(0, 1, 0, 0, 0);
    idle(1);
    check("unlap_disp", 32'(disp_all), 32'h000080);
    check("unlap_state", 32'(state), 32'd1);

    // Simultaneous start+lap+tick with prescaler at its last count
    ticks(MSEC - 1);
    cycle(1, 1, 0, 1, 0);
    check("simul_state", 32'(state), 32'd2);
    idle(1);
    check("simul_disp", 32'(disp_all), 32'h000081);

    // Reset during LAP at 00:03.47
    cycle(0, 0, 1, 0, 0);
    cycle(1, 0, 0, 0, 0);
    ticks(3470);
    cycle(0, 1, 0, 0, 0);
    idle(1);
    check("lap347_disp", 32'(disp_all), 32'h000347);
    cycle(0, 0, 0, 1, 1);
    check("midrst_state", 32'(state), 32'd0);
    check("midrst_disp", 32'(disp_all), 32'h0);
    check("midrst_running", 32'(running), 32'd0);

    // Randomized commands, ticks and occasional reset
    for (int i = 0; i < 20000; i++) begin
      cycle($urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0,
            $urandom_range(0, 23) == 0, $urandom_range(0, 1) == 1,
            $urandom_range(0, 1999) == 0);
    end

    // Rollover on the fast instance: preload 59:59.99 while idle
    ro_cycle(0, 0, 1);
    force dut_r.u_min10.digit  = 4'd5;
    force dut_r.u_min1.digit   = 4'd9;
    force dut_r.u_sec10.digit  = 4'd5;
    force dut_r.u_sec1.digit   = 4'd9;
    force dut_r.u_csec10.digit = 4'd9;
    force dut_r.u_csec1.digit  = 4'd9;
    ro_cycle(0, 0, 0);
    release dut_r.u_min10.digit;
    release dut_r.u_min1.digit;
    release dut_r.u_sec10.digit;
    release dut_r.u_sec1.digit;
    release dut_r.u_csec10.digit;
    release dut_r.u_csec1.digit;
    ro_cycle(0, 0, 0);
    check("ro_preload", 32'(ro_disp), 32'h595999);
    ro_cycle(1, 0, 0);
    check("ro_run_state", 32'(ro_state), 32'd1);
    check("ro_no_early", 32'(ro_rollover), 32'd0);
    ro_pulses = 0;
    ro_cycle(0, 1, 0);
    ro_pulses += int'(ro_rollover);
    for (int i = 0; i < 3; i++) begin
      ro_cycle(0, 0, 0);
      ro_pulses += int'(ro_rollover);
    end
    check("ro_pulse_count", 32'(ro_pulses), 32'd1);
    check("ro_wrap_disp", 32'(ro_disp), 32'h0);
    check("ro_wrap_state", 32'(ro_state), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_stopwatch_ctrl
`default_nettype wire

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 SHALL have parameter MSEC_PER_CSEC, default 10: clk_msec ticks per hundredth-second (benches may shrink it).
REQ-002 SHALL have port clk  input  1  system clock; all logic on posedge.
REQ-003 SHALL have port reset_p  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port clk_msec  input  1  one-cycle millisecond tick pulse from the timebase.
REQ-005 SHALL have port btn_start  input  1  one-cycle start/stop command pulse (already debounced and edge-detected).
REQ-006 SHALL have port btn_lap  input  1  one-cycle lap command pulse.
REQ-007 SHALL have port btn_clear  input  1  one-cycle clear command pulse.
REQ-008 SHALL have ports disp_min10, disp_min1, disp_sec10, disp_sec1, disp_csec10, disp_csec1  output  4 each  registered BCD display digits.
REQ-009 SHALL have port state  output  2  current FSM state: IDLE=0, RUN=1, PAUSE=2, LAP=3.
REQ-010 SHALL have port running  output  1  high in RUN or LAP.
REQ-011 SHALL have port rollover  output  1  one-cycle pulse on wrap from 59:59.99 to 00:00.00.

Function
REQ-012 SHALL keep an internal prescaler 0..MSEC_PER_CSEC-1 that advances on clk_msec only while state is RUN or LAP.
REQ-013 SHALL increment the live BCD time by one hundredth on a prescaler wrap; digit limits: csec1 9, csec10 9, sec1 9, sec10 5, min1 9, min10 5; each digit carries into the next on wrap.
REQ-014 SHALL wrap the live time from 59:59.99 to 00:00.00, pulse rollover for exactly one cycle, and stay in the current state.
REQ-015 SHALL process at most one command per cycle, with priority btn_clear > btn_start > btn_lap; lower-priority commands in the same cycle are dropped.
REQ-016 SHALL apply these transitions: IDLE+start->RUN; RUN+start->PAUSE; RUN+lap->LAP; LAP+lap->RUN; LAP+start->PAUSE; PAUSE+start->RUN; PAUSE+clear->IDLE.
REQ-017 SHALL ignore all other command/state combinations (clear in IDLE/RUN/LAP, lap in IDLE/PAUSE) with no state or count change.
REQ-018 SHALL decide tick gating from the pre-transition state, so a clk_msec coinciding with RUN+start is counted and one coinciding with PAUSE+start is not.
REQ-019 SHALL zero the prescaler, live time and lap latch on PAUSE+clear.
REQ-020 SHALL hold the prescaler value across PAUSE; resuming does not restart the partial hundredth.
REQ-021 SHALL capture the live time into the lap latch on RUN+lap, as the value before any same-cycle increment.
REQ-022 SHALL drive the disp_* registers from the lap latch in LAP and from the live time in every other state, with one cycle of latency after the source changes.
REQ-023 SHALL never produce a non-BCD digit or a tens digit above 5 on any disp_* output.

Reset
REQ-024 SHALL, with reset_p high at a clock edge, set state=IDLE, zero the prescaler, live time, lap latch and all disp_* digits, and clear running and rollover on that edge.
REQ-025 SHALL let reset_p override every command and tick, including mid-RUN and mid-LAP.

Structure
REQ-026 SHALL place state encodings and digit limit constants (9, 5) in a shared package, stopwatch_pkg.
REQ-027 SHALL instantiate a sub-module bcd_digit_cnt (parameter MAX; inputs clk, reset_p, clr, inc; outputs digit[3:0], carry) once per digit.

Verification
REQ-028 Count: reset, btn_start, 1000 clk_msec ticks, wait 2 cycles -> disp 00:01.00, state=RUN, running=1.
REQ-029 Rollover: preload by running to 59:59.99 (MSEC_PER_CSEC=1), one more tick -> disp 00:00.00, rollover high exactly 1 cycle, state=RUN.
REQ-030 Lap: run to 00:00.50, btn_lap, 300 more ticks -> disp stays 00:00.50, state=LAP; btn_lap again -> disp 00:00.80 after 1 cycle, state=RUN.
REQ-031 Pause/clear: btn_clear in RUN at 00:02.00 -> ignored; btn_start -> PAUSE, 500 ticks -> disp 00:02.00; btn_clear -> IDLE, all digits 0.
REQ-032 Simultaneous: in RUN, btn_start+btn_lap+clk_msec in one cycle (prescaler at 9) -> state=PAUSE, hundredth counted, lap latch unchanged.
REQ-033 Reset mid-run: reset_p for 1 cycle during LAP at 00:03.47 -> next cycle state=IDLE, all digits 0, running=0.
